// File: rtl/ipf_seq_pkg.sv
// Shared types and helpers for the IPF LCU sequencer: FSM encoding, LCU size codes,
// parameter-set layout and size-derived constants.
package ipf_seq_pkg;
    localparam int IMG_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        LCU_16  = 2'd0,
        LCU_32  = 2'd1,
        LCU_64  = 2'd2,
        LCU_RSV = 2'd3
    } lcu_size_e;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  band_pos;
        logic        wo_class;
        logic [15:0] offset;
    } prm_t;

    // Reserved code falls through to 64.
    function automatic logic [5:0] lcu_mask(input logic [1:0] sz);
        case (lcu_size_e'(sz))
            LCU_16:  return 6'd15;
            LCU_32:  return 6'd31;
            default: return 6'd63;
        endcase
    endfunction

    function automatic logic [3:0] lcus_per_row(input logic [1:0] sz);
        return 4'(IMG_W / (int'(lcu_mask(sz)) + 1));
    endfunction
endpackage

// File: rtl/ipf_prm_fifo.sv
// Synchronous parameter-set FIFO; a push while full is dropped even if a pop
// happens in the same cycle.
module ipf_prm_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_wr, do_rd;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign rdata = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + AW'(1);
            if (do_rd) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wdata;
    end
endmodule

// File: rtl/ipf_lcu_sequencer.sv
// IPF front-end: reads the image in LCU raster order and streams it with per-LCU
// parameters. Optional stall counter under IPF_SEQ_STALL_CNT_EN.
module ipf_lcu_sequencer
    import ipf_seq_pkg::*;
#(
    parameter int PRM_DEPTH = 4,
    parameter int IMG_LOG   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           cfg_lcu_size,
    input  logic                 prm_wr,
    input  logic [1:0]           prm_type,
    input  logic [4:0]           prm_band_pos,
    input  logic                 prm_wo_class,
    input  logic [15:0]          prm_offset,
    output logic                 prm_full,
    output logic                 img_rd,
    output logic [2*IMG_LOG-1:0] img_addr,
    input  logic [7:0]           img_rdata,
    input  logic                 ipf_busy,
    input  logic                 ipf_finish,
    output logic                 in_en,
    output logic [7:0]           din,
    output logic [1:0]           ipf_type,
    output logic [4:0]           ipf_band_pos,
    output logic                 ipf_wo_class,
    output logic [15:0]          ipf_offset,
    output logic [2:0]           lcu_x,
    output logic [2:0]           lcu_y,
    output logic [1:0]           lcu_size,
    output logic                 done
`ifdef IPF_SEQ_STALL_CNT_EN
    ,output logic [15:0]         stall_cnt
`endif
);
    localparam int AW = 2*IMG_LOG;

    seq_state_e    state;
    logic [5:0]    col, row, mask;
    logic [2:0]    cur_x, cur_y, last_lcu;
    logic [6:0]    size_px;
    prm_t          shadow, fifo_rdata;
    logic          fifo_empty, pop, rd_issue;
    logic [AW-1:0] pix_row, pix_col;

    assign mask     = lcu_mask(lcu_size);
    assign last_lcu = 3'(lcus_per_row(lcu_size) - 4'd1);
    assign size_px  = 7'(mask) + 7'd1;
    assign pop      = (state == ST_LOAD) && !fifo_empty;
    assign rd_issue = (state == ST_STREAM) && !ipf_busy;

    assign pix_row  = AW'(cur_y) * AW'(size_px) + AW'(row);
    assign pix_col  = AW'(cur_x) * AW'(size_px) + AW'(col);
    assign img_rd   = rd_issue;
    assign img_addr = rd_issue ? AW'((pix_row << IMG_LOG) + pix_col) : '0;
    assign din      = in_en ? img_rdata : '0;

    ipf_prm_fifo #(.DEPTH(PRM_DEPTH), .W($bits(prm_t))) u_prm_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (prm_wr),
        .wdata ({prm_type, prm_band_pos, prm_wo_class, prm_offset}),
        .rd    (pop),
        .rdata (fifo_rdata),
        .full  (prm_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            lcu_size     <= '0;
            col          <= '0;
            row          <= '0;
            cur_x        <= '0;
            cur_y        <= '0;
            shadow       <= '0;
            ipf_type     <= '0;
            ipf_band_pos <= '0;
            ipf_wo_class <= 1'b0;
            ipf_offset   <= '0;
            lcu_x        <= '0;
            lcu_y        <= '0;
            in_en        <= 1'b0;
            done         <= 1'b0;
        end else begin
            in_en <= rd_issue;
            done  <= 1'b0;
            // Visible LCU state moves with the in_en of the LCU's first pixel.
            if (rd_issue && col == '0 && row == '0) begin
                {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} <= shadow;
                lcu_x <= cur_x;
                lcu_y <= cur_y;
            end
            case (state)
                ST_IDLE: if (start) begin
                    lcu_size <= cfg_lcu_size;
                    col      <= '0;
                    row      <= '0;
                    cur_x    <= '0;
                    cur_y    <= '0;
                    state    <= ST_LOAD;
                end
                ST_LOAD: if (!fifo_empty) begin
                    shadow <= fifo_rdata;
                    state  <= ST_STREAM;
                end
                ST_STREAM: if (!ipf_busy) begin
                    if (col != mask) begin
                        col <= col + 6'd1;
                    end else begin
                        col <= '0;
                        if (row != mask) begin
                            row <= row + 6'd1;
                        end else begin
                            row <= '0;
                            if (cur_x != last_lcu) begin
                                cur_x <= cur_x + 3'd1;
                                state <= ST_LOAD;
                            end else begin
                                cur_x <= '0;
                                if (cur_y == last_lcu) begin
                                    state <= ST_DRAIN;
                                end else begin
                                    cur_y <= cur_y + 3'd1;
                                    state <= ST_LOAD;
                                end
                            end
                        end
                    end
                end
                ST_DRAIN: if (ipf_finish) begin
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IPF_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_cnt <= '0;
        end else if (((state == ST_LOAD && fifo_empty) || (state == ST_STREAM && ipf_busy))
                     && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ipf_lcu_sequencer.sv
// Randomized bench for ipf_lcu_sequencer against a raster-order reference model.
module tb_ipf_lcu_sequencer;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [1:0]  cfg_lcu_size = '0;
    logic        prm_wr = 1'b0;
    logic [1:0]  prm_type = '0;
    logic [4:0]  prm_band_pos = '0;
    logic        prm_wo_class = 1'b0;
    logic [15:0] prm_offset = '0;
    logic        prm_full, img_rd, in_en, done, ipf_wo_class;
    logic [13:0] img_addr;
    logic [7:0]  img_rdata = '0, din;
    logic        ipf_busy = 1'b0, ipf_finish = 1'b0;
    logic [1:0]  ipf_type, lcu_size;
    logic [4:0]  ipf_band_pos;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x, lcu_y;
`ifdef IPF_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    ipf_lcu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg_lcu_size),
        .prm_wr(prm_wr), .prm_type(prm_type), .prm_band_pos(prm_band_pos),
        .prm_wo_class(prm_wo_class), .prm_offset(prm_offset), .prm_full(prm_full),
        .img_rd(img_rd), .img_addr(img_addr), .img_rdata(img_rdata),
        .ipf_busy(ipf_busy), .ipf_finish(ipf_finish), .in_en(in_en), .din(din),
        .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
        .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
        .done(done)
`ifdef IPF_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_fn(input int a);
        return 8'((a * 29) ^ (a >> 7) ^ 8'h5A);
    endfunction

    // k-th pixel of the frame in LCU raster order, pixels row-major inside the LCU.
    function automatic int exp_addr(input int k, input int s);
        int lpr, lcu, p;
        lpr = 128 / s;
        lcu = k / (s * s);
        p   = k % (s * s);
        return ((lcu / lpr) * s + p / s) * 128 + (lcu % lpr) * s + p % s;
    endfunction

    always @(posedge clk) img_rdata <= img_rd ? mem_fn(int'(img_addr)) : 8'($urandom);

    int          sz = 16, px_cnt = 0, rd_cnt = 0, done_cnt = 0, n_acc = 0, n_push = 0;
    int          first_x1 = -1, n_mid = 0, busy_mode = 0, feed_gap = 0, gap_ctr = 0;
    bit          feed_force = 1'b0;
    logic [23:0] acc [64];
    logic [23:0] pend [$];
    logic        full_seen [8];
    int          rd_addr [16384];
    int          addr_a [16384];
    int          chg [$];
    logic [15:0] prev_off = '0;

    // Host pusher: a push is kept only if the FIFO was not full when it was offered.
    initial forever begin
        logic [23:0] set;
        @(posedge clk); #1;
        prm_wr = 1'b0;
        if (gap_ctr > 0) gap_ctr--;
        else if (pend.size() > 0 && (feed_force || !prm_full)) begin
            set = pend.pop_front();
            {prm_type, prm_band_pos, prm_wo_class, prm_offset} = set;
            prm_wr = 1'b1;
            if (n_push < 8) full_seen[n_push] = prm_full;
            n_push++;
            if (!prm_full && n_acc < 64) begin
                acc[n_acc] = set;
                n_acc++;
            end
            gap_ctr = feed_gap;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (busy_mode)
            0:       ipf_busy = 1'b0;
            1:       ipf_busy = ~ipf_busy;
            default: ipf_busy = ($urandom_range(7) == 0);
        endcase
    end

    initial forever begin
        int lcu, lpr;
        @(negedge clk);
        if (img_rd) begin
            chk("rd_while_busy", 32'(ipf_busy), 0);
            if (rd_cnt < 16384) begin
                chk("rd_addr", 32'(img_addr), exp_addr(rd_cnt, sz));
                chk("prm_avail", 32'((rd_cnt / (sz * sz)) < n_acc), 1);
                rd_addr[rd_cnt] = int'(img_addr);
            end else chk("rd_overrun", rd_cnt, 16383);
            rd_cnt++;
        end
        if (in_en) begin
            if (px_cnt < 16384) begin
                lpr = 128 / sz;
                lcu = px_cnt / (sz * sz);
                chk("din", 32'(din), 32'(mem_fn(exp_addr(px_cnt, sz))));
                chk("lcu_x", 32'(lcu_x), lcu % lpr);
                chk("lcu_y", 32'(lcu_y), lcu / lpr);
                chk("prm", 32'({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}), 32'(acc[lcu]));
                if (lcu_x == 3'd1 && first_x1 < 0) first_x1 = px_cnt;
                if (px_cnt > 0 && ipf_offset != prev_off) begin
                    chg.push_back(px_cnt);
                    if (px_cnt % (sz * sz) != 0) n_mid++;
                end
                prev_off = ipf_offset;
            end else chk("px_overrun", px_cnt, 16383);
            px_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_px(input int n, input int budget);
        int c = 0;
        while (px_cnt < n && c < budget) begin step(); c++; end
        chk("px_reached", (px_cnt >= n) ? n : px_cnt, n);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_outs"}, 32'({in_en, img_rd, done, prm_full, din, img_addr}), 0);
        chk({tag, "_prm"}, 32'({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}), 0);
        chk({tag, "_lcu"}, 32'({lcu_x, lcu_y, lcu_size}), 0);
    endtask

    task automatic begin_frame(input int cfg, input int s, input int mode, input int gap, input bit keep);
        px_cnt = 0; rd_cnt = 0; done_cnt = 0; first_x1 = -1; n_mid = 0;
        chg.delete();
        sz = s;
        busy_mode = mode;
        if (!keep) begin
            n_acc = 0;
            gap_ctr = 0;
            feed_gap = gap;
            for (int i = 0; i < (128 / s) * (128 / s); i++) pend.push_back(24'($urandom));
        end
        step(); start = 1'b1; cfg_lcu_size = 2'(cfg);
        step(); start = 1'b0;
    endtask

    task automatic end_frame(input int cfg);
        wait_px(16384, 60000);
        step(4);
        chk("early_done", done_cnt, 0);
        chk("px_total", px_cnt, 16384);
        chk("rd_total", rd_cnt, 16384);
        chk("lcu_size", 32'(lcu_size), cfg);
        ipf_finish = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("done_pulse", 32'(done), 1);
        ipf_finish = 1'b0;
        @(negedge clk);
        chk("done_width", 32'(done), 0);
        chk("done_cnt", done_cnt, 1);
        busy_mode = 0;
        step();
    endtask

    initial begin
        int nbad;
        #2 reset = 1'b1;
        step(3);
        chk_zero_outputs("reset");
        reset = 1'b0;
        step(2);

        // Size 16, FIFO kept topped up, no back-pressure.
        begin_frame(0, 16, 0, 0, 1'b0);
        end_frame(0);
        chk("addr_0", rd_addr[0], 0);
        chk("addr_16", rd_addr[16], 128);
        chk("addr_256", rd_addr[256], 16);
        chk("first_lcu_x1", first_x1, 256);
        for (int i = 0; i < 16384; i++) addr_a[i] = rd_addr[i];

        // Five pushes into an idle depth-4 FIFO; the fifth must be dropped.
        n_acc = 0; gap_ctr = 0; feed_gap = 0; feed_force = 1'b1; n_push = 0;
        pend.push_back({8'($urandom), 16'h1234});
        pend.push_back({8'($urandom), 16'h5678});
        pend.push_back({8'($urandom), 16'h9ABC});
        pend.push_back({8'($urandom), 16'hDEF0});
        pend.push_back({8'($urandom), 16'hAAAA});
        step(8);
        feed_force = 1'b0;
        chk("full_before_4th", 32'(full_seen[3]), 0);
        chk("full_before_5th", 32'(full_seen[4]), 1);
        chk("full_after_5", 32'(prm_full), 1);
        begin_frame(3, 64, 0, 0, 1'b1);
        end_frame(3);
        chk("off_chg_n", chg.size(), 3);
        chk("off_chg_0", chg[0], 4096);
        chk("off_chg_1", chg[1], 8192);
        chk("off_chg_2", chg[2], 12288);
        chk("last_addr", rd_addr[16383], 32'h3FFF);

        // Size 32, starved FIFO (one set per 1100 cycles), stray start mid-frame.
        begin_frame(1, 32, 0, 1099, 1'b0);
        wait_px(3000, 10000);
        start = 1'b1; cfg_lcu_size = 2'd0;
        step();
        start = 1'b0;
        end_frame(1);
        chk("mid_lcu_chg", n_mid, 0);
`ifdef IPF_SEQ_STALL_CNT_EN
        chk("stall_nz", 32'(stall_cnt != 16'd0), 1);
`endif

        // Size 16 with busy toggling, aborted by reset at pixel 5000.
        begin_frame(0, 16, 1, 0, 1'b0);
        wait_px(5000, 20000);
        reset = 1'b1;
        pend.delete();
        busy_mode = 0;
        @(negedge clk);
        chk_zero_outputs("abort");
        nbad = 0;
        for (int i = 0; i < rd_cnt && i < 16384; i++) if (rd_addr[i] != addr_a[i]) nbad++;
        chk("addr_vs_nostall", nbad, 0);
        step(3);
        reset = 1'b0;
        step(2);
        chk("abort_no_done", done_cnt, 0);

        // Restart after abort with random back-pressure.
        begin_frame(0, 16, 2, 0, 1'b0);
        end_frame(0);
        chk("restart_addr0", rd_addr[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ipf_lcu_sequencer.md
Name: ipf_lcu_sequencer

Overview:
- Front-end controller for the image post-filter (IPF) datapath.
- Reads a 128x128 8-bit image from an external single-port image memory in LCU raster order: LCUs left-to-right and top-to-bottom, pixels row-major inside each LCU.
- Streams the pixels to the filter on in_en/din, together with the per-LCU filter parameters popped from an internal parameter FIFO loaded by the host.
- Sequences frame start, per-LCU parameter hand-off, back-pressure stalls and end-of-frame completion.

Parameters:
- PRM_DEPTH, 4, parameter FIFO depth in entries (power of two, >=2)
- IMG_LOG, 7, log2 of the image width/height (128)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle frame start pulse; sampled in IDLE only
- cfg_lcu_size  in  2  0=16, 1=32, 2=64, 3=reserved (treated as 64); latched on start
- prm_wr  in  1  push one LCU parameter set
- prm_type  in  2  filter type for pushed set
- prm_band_pos  in  5  band position for pushed set
- prm_wo_class  in  1  0=horizontal, 1=vertical for pushed set
- prm_offset  in  16  four 4-bit signed offsets for pushed set
- prm_full  out  1  FIFO full; a push while full is dropped
- img_rd  out  1  image memory read strobe
- img_addr  out  14  image memory address = row*128 + col
- img_rdata  in  8  read data, valid exactly one cycle after img_rd
- ipf_busy  in  1  filter back-pressure; no read is issued in a cycle where this is high
- ipf_finish  in  1  filter end-of-frame indication
- in_en  out  1  pixel valid to filter
- din  out  8  pixel to filter (img_rdata pass-through)
- ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset  out  2/5/1/16  current LCU parameters
- lcu_x, lcu_y  out  3/3  current LCU index
- lcu_size  out  2  latched cfg_lcu_size
- done  out  1  one-cycle end-of-frame pulse

Behaviour:
Reset:
- All outputs 0; FSM to IDLE; FIFO emptied; counters cleared.
- Reset asserted mid-frame aborts the frame. Nothing is completed and no done pulse is issued.

FSM states:
- IDLE: waits for start. On start, latch size, clear col/row/lcu_x/lcu_y, go to LOAD. start in any other state is ignored.
- LOAD: at an LCU boundary, waits for FIFO non-empty.
  - Pops one entry into the parameter shadow registers, then goes to STREAM.
  - If the FIFO is empty, stays in LOAD and issues no reads. This is a bubble, not an error.
- STREAM: issues one read per cycle when ipf_busy=0.
  - col increments and wraps at size-1 to 0, then row increments.
  - After the read of pixel (size-1, size-1), advance lcu_x; at 128/size-1 wrap lcu_x to 0 and increment lcu_y.
  - Go to LOAD, or to DRAIN if this was the last LCU (lcu_x = lcu_y = 128/size-1).
- DRAIN: no reads. Waits for ipf_finish, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.

Address:
- img_addr = ((lcu_y*size + row) << 7) + lcu_x*size + col, truncated to 14 bits.
- Valid only while img_rd=1.

Latency:
- in_en is img_rd delayed one cycle; din = img_rdata in that cycle.
- Parameter and lcu_x/lcu_y outputs update in the same cycle as the in_en of an LCU's first pixel.
- They then hold until the in_en of the next LCU's first pixel, so they stay stable during the last pixel of an LCU.

FIFO:
- Push and pop in the same cycle are both honoured.
- prm_full reflects occupancy before the cycle's pop, so a push is dropped if the FIFO was full, even when a pop happens in the same cycle.

Totals:
- Exactly 16384 in_en pulses per frame, independent of stalls.
- 64/16/4 pops per frame for sizes 16/32/64.

Optional Feature:
- Macro: IPF_SEQ_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0]. It counts cycles in LOAD or STREAM in which no read was issued (FIFO empty or ipf_busy). It clears on start, saturates at 0xFFFF, and holds after done.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ipf_seq_pkg holds:
  - the FSM state encoding (IDLE, LOAD, STREAM, DRAIN, DONE);
  - the LCU size codes;
  - IMG_W=128;
  - a size-to-(size-1) mask function;
  - a size-to-LCUs-per-row function.
- Sub-module ipf_prm_fifo: synchronous FIFO of PRM_DEPTH x 24-bit parameter sets, with full/empty flags.

Test Plan:
- Size 16, 64 sets preloaded via pushes, ipf_busy=0:
  - 16384 in_en pulses;
  - issue #0 addr 0, #16 addr 128, #256 addr 16;
  - lcu_x=1 first seen with in_en of pixel #256;
  - done one cycle after ipf_finish.
- Size 64, push 4 sets with distinct prm_offset (0x1234, 0x5678, 0x9ABC, 0xDEF0):
  - ipf_offset changes exactly at in_en #4096, #8192, #12288;
  - last address 0x3FFF.
- Size 32, FIFO starts empty, one set pushed per 1100 cycles:
  - LOAD bubbles with img_rd=0;
  - still exactly 16384 pixels;
  - no parameter change mid-LCU;
  - stall_cnt non-zero when IPF_SEQ_STALL_CNT_EN is defined.
- ipf_busy toggling every other cycle during STREAM:
  - img_rd never high while ipf_busy=1;
  - address sequence identical to the no-stall run.
- Push 5 sets into a depth-4 FIFO with no pops:
  - prm_full=1 after the 4th push;
  - 5th set dropped;
  - the frame uses sets 1-4 in order.
- Reset asserted at pixel #5000:
  - all outputs 0 next cycle, FIFO empty;
  - a new start and reload restart from addr 0;
  - no done pulse from the aborted frame.
